// File: rtl/spi_slave_responder_pkg.sv
// ============================================================================
// Module : spi_slave_responder_pkg
// Brief  : Shared SPI mode encodings, FSM state type and width defaults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_slave_responder_pkg;

    localparam int DATA_W_DEF = 32;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_slave_responder_input_sync.sv
// ============================================================================
// Module : spi_input_sync
// Brief  : Multi-flop synchronizer with history flop and rise/fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule

`default_nettype wire

// File: rtl/spi_slave_responder.sv
// ============================================================================
// Module : spi_slave_responder
// Brief  : SPI slave, all CPOL/CPHA modes, 1..DATA_W bit frames, MSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk_polarity,
    input  logic              spi_clk_phase,
    input  logic [7:0]        data_len,
    input  logic              spi_cs,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_taken,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_error
);

    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_clk_sync, w_clk_rise, w_clk_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic w_mosi;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (spi_cs),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (spi_clk),
        .o_sync  (w_clk_sync),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_mosi_sync <= '0;
        else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // The cs synchronizer resets to "deselected"; hold off leaving IDLE until
    // it carries a real pin sample, or a held-low cs would look like a new frame.
    logic [FLUSH_W-1:0] r_flush;
    logic               w_sync_ready;
    assign w_sync_ready = (r_flush == FLUSH_W'(SYNC_STAGES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          r_flush <= '0;
        else if (!w_sync_ready) r_flush <= r_flush + FLUSH_W'(1);
    end

    // Leading edge leaves the CPOL level, trailing edge returns to it.
    logic w_clk_edge, w_lead, w_trail, w_sample, w_shift;
    assign w_clk_edge = w_clk_rise | w_clk_fall;
    assign w_lead     = w_clk_edge & (w_clk_sync != spi_clk_polarity);
    assign w_trail    = w_clk_edge & (w_clk_sync == spi_clk_polarity);

    always_comb begin
        w_sample = 1'b0;
        w_shift  = 1'b0;
        case ({spi_clk_polarity, spi_clk_phase})
            MODE0, MODE2: begin w_sample = w_lead;  w_shift = w_trail; end
            MODE1, MODE3: begin w_sample = w_trail; w_shift = w_lead;  end
            default:      begin w_sample = 1'b0;    w_shift = 1'b0;    end
        endcase
    end

    state_t r_state, w_state_nxt;
    logic   w_start, w_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_sync_ready && w_cs_sync) w_state_nxt = ST_ARMED;
            ST_ARMED:  if (w_cs_fall) begin
                           w_state_nxt = ST_ACTIVE;
                           w_start     = 1'b1;
                       end
            ST_ACTIVE: if (w_cs_rise) begin
                           w_state_nxt = ST_ARMED;
                           w_end       = 1'b1;
                       end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    logic [CNT_W-1:0]  w_eff_len;
    logic [CNT_W-1:0]  r_len, r_bit_cnt;
    logic [DATA_W-1:0] r_tx_sr, r_rx_sr, r_rx_data;
    logic              r_overrun, r_tx_taken, r_rx_valid, r_frame_error;
    logic              w_edge_ok, w_bit_full;

    assign w_eff_len  = (data_len == 8'd0 || int'(data_len) > DATA_W)
                        ? CNT_W'(DATA_W) : CNT_W'(data_len);
    // A cs rise in the same cycle as a clock edge ends the frame; the edge is dropped.
    assign w_edge_ok  = (r_state == ST_ACTIVE) && !w_cs_rise;
    assign w_bit_full = (r_bit_cnt == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len         <= CNT_W'(DATA_W);
            r_bit_cnt     <= '0;
            r_tx_sr       <= '0;
            r_rx_sr       <= '0;
            r_rx_data     <= '0;
            r_overrun     <= 1'b0;
            r_tx_taken    <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_tx_taken    <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_start) begin
                r_len      <= w_eff_len;
                r_tx_sr    <= tx_data;
                r_tx_taken <= 1'b1;
                r_bit_cnt  <= '0;
                r_rx_sr    <= '0;
                r_overrun  <= 1'b0;
            end else if (w_end) begin
                if (w_bit_full && !r_overrun) begin
                    r_rx_data  <= r_rx_sr;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_frame_error <= 1'b1;
                end
            end else if (w_edge_ok) begin
                if (w_sample) begin
                    r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_mosi};
                    if (w_bit_full) r_overrun <= 1'b1;
                    else            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
                // With CPHA=1 the first leading edge finds bit len-1 already on the pin.
                if (w_shift && (r_bit_cnt != '0 || !spi_clk_phase))
                    r_tx_sr <= r_tx_sr << 1;
            end
        end
    end

    logic [DATA_W-1:0] w_msb_sel;
    assign w_msb_sel   = DATA_W'(1) << (r_len - CNT_W'(1));

    assign spi_miso    = (r_state == ST_ACTIVE) && (|(r_tx_sr & w_msb_sel));
    assign spi_miso_oe = (r_state == ST_ACTIVE);
    assign tx_taken    = r_tx_taken;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
// ============================================================================
// Module : tb_spi_slave_responder
// Brief  : Self-checking bench: bit-banged SPI master against a frame model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_responder;

    localparam int DW = 32;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          spi_clk_polarity, spi_clk_phase;
    logic [7:0]    data_len;
    logic          spi_cs, spi_clk, spi_mosi;
    logic          spi_miso, spi_miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_taken;
    logic [DW-1:0] rx_data;
    logic          rx_valid, frame_error;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_rv  = 0;
    int cnt_fe  = 0;
    int cnt_tt  = 0;
    logic [DW-1:0] rx_model = '0;

    spi_slave_responder #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .spi_clk_polarity (spi_clk_polarity),
        .spi_clk_phase    (spi_clk_phase),
        .data_len         (data_len),
        .spi_cs           (spi_cs),
        .spi_clk          (spi_clk),
        .spi_mosi         (spi_mosi),
        .spi_miso         (spi_miso),
        .spi_miso_oe      (spi_miso_oe),
        .tx_data          (tx_data),
        .tx_taken         (tx_taken),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .frame_error      (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)    cnt_rv++;
        if (frame_error) cnt_fe++;
        if (tx_taken)    cnt_tt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One master frame of nbits bits; mw holds the MOSI bits right-justified.
    task automatic run_frame(input string name, input logic [1:0] mode, input int dlen,
                             input logic [31:0] tx, input logic [63:0] mw, input int nbits);
        int elen;
        int rv0, fe0, tt0;
        logic ok;
        logic [63:0] obs, exp, mask;
        elen = (dlen == 0 || dlen > DW) ? DW : dlen;
        obs  = '0;
        exp  = '0;
        spi_clk_polarity = mode[1];
        spi_clk_phase    = mode[0];
        spi_clk          = mode[1];
        data_len         = dlen[7:0];
        tx_data          = tx;
        wait_n(H);
        rv0 = cnt_rv; fe0 = cnt_fe; tt0 = cnt_tt;
        spi_cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (!mode[0]) begin
                spi_mosi = mw[nbits-1-i];
                wait_n(H);
                obs = {obs[62:0], spi_miso};
                spi_clk = ~mode[1];
                wait_n(H);
                spi_clk = mode[1];
            end else begin
                wait_n(H);
                spi_clk  = ~mode[1];
                spi_mosi = mw[nbits-1-i];
                wait_n(H);
                obs = {obs[62:0], spi_miso};
                spi_clk = mode[1];
            end
            exp = {exp[62:0], (i < elen) ? tx[elen-1-i] : 1'b0};
            if (i == 0) check({name, "_oe_active"}, {63'd0, spi_miso_oe}, 64'd1);
        end
        wait_n(H);
        spi_cs = 1'b1;
        wait_n(20);
        ok   = (nbits == elen);
        mask = (64'd1 << elen) - 64'd1;
        if (ok) rx_model = DW'(mw & mask);
        check({name, "_miso"},     obs, exp);
        check({name, "_rx_valid"}, 64'(cnt_rv - rv0), {63'd0, ok});
        check({name, "_frame_err"}, 64'(cnt_fe - fe0), {63'd0, !ok});
        check({name, "_tx_taken"}, 64'(cnt_tt - tt0), 64'd1);
        check({name, "_rx_data"},  {32'd0, rx_data}, {32'd0, rx_model});
        check({name, "_oe_idle"},  {63'd0, spi_miso_oe}, 64'd0);
    endtask

    task automatic mode0_bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = 1'($urandom);
            wait_n(H);
            spi_clk = 1'b1;
            wait_n(H);
            spi_clk = 1'b0;
        end
    endtask

    initial begin
        int rv0, fe0, tt0;
        int elen, dlen, nb;
        reset_n = 1'b0;
        spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        spi_clk_polarity = 1'b0; spi_clk_phase = 1'b0;
        data_len = 8'd8; tx_data = '0;
        wait_n(3);
        check("rst_miso",   {63'd0, spi_miso},    64'd0);
        check("rst_oe",     {63'd0, spi_miso_oe}, 64'd0);
        check("rst_txtk",   {63'd0, tx_taken},    64'd0);
        check("rst_rxdata", {32'd0, rx_data},     64'd0);
        check("rst_rxv",    {63'd0, rx_valid},    64'd0);
        check("rst_ferr",   {63'd0, frame_error}, 64'd0);
        reset_n = 1'b1;
        wait_n(10);

        run_frame("m0_len8",   2'b00, 8,  32'h3C,   64'hA5, 8);
        run_frame("m3_len16",  2'b11, 16, 32'hBEEF, 64'h1234, 16);
        run_frame("m1_short",  2'b01, 8,  $urandom, 64'($urandom), 5);
        run_frame("m2_over",   2'b10, 8,  $urandom, 64'($urandom), 9);
        run_frame("len1",      2'b00, 1,  $urandom, 64'h1, 1);
        run_frame("len32",     2'b01, 32, $urandom, 64'hDEADBEEF, 32);
        run_frame("len0",      2'b10, 0,  $urandom, 64'($urandom), 32);

        // Reset in the middle of a frame with cs held low.
        spi_clk_polarity = 1'b0; spi_clk_phase = 1'b0; spi_clk = 1'b0;
        data_len = 8'd8; tx_data = 32'hFF;
        wait_n(H);
        spi_cs = 1'b0;
        mode0_bits(3);
        reset_n = 1'b0;
        wait_n(2);
        check("midrst_oe",     {63'd0, spi_miso_oe}, 64'd0);
        check("midrst_rxdata", {32'd0, rx_data},     64'd0);
        rx_model = '0;
        reset_n = 1'b1;
        rv0 = cnt_rv; fe0 = cnt_fe; tt0 = cnt_tt;
        mode0_bits(5);
        check("midrst_oe_held", {63'd0, spi_miso_oe}, 64'd0);
        check("midrst_miso",    {63'd0, spi_miso},    64'd0);
        spi_cs = 1'b1;
        wait_n(20);
        check("midrst_pulses", 64'((cnt_rv - rv0) + (cnt_fe - fe0) + (cnt_tt - tt0)), 64'd0);
        run_frame("after_rst", 2'b00, 8, 32'h5A, 64'hC3, 8);

        for (int k = 0; k < 14; k++) begin
            dlen = (k % 5 == 4) ? int'($urandom_range(33, 60)) : int'($urandom_range(1, 32));
            elen = (dlen == 0 || dlen > DW) ? DW : dlen;
            case ($urandom_range(0, 3))
                0:       nb = (elen > 1) ? elen - 1 : elen + 1;
                1:       nb = elen + 1;
                default: nb = elen;
            endcase
            run_frame($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), dlen,
                      $urandom, {$urandom, $urandom}, nb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_responder.md
# spi_slave_responder

SPI responder (slave) end of the rangefinder SPI link: accepts externally driven SPI CS/CLK/MOSI, oversamples them in the system clock domain, shifts received bits into a receive word and drives MISO from a preloaded transmit word. Supports all four CPOL/CPHA modes and frame lengths of 1..DATA_W bits, MSB first. It sits between the board SPI pins and the register/command logic, mirroring the framing produced by the SPI master CS/CLK generator.

## Interface
- DATA_W, 32: width of tx/rx words; maximum frame length in bits.
- SYNC_STAGES, 2: synchronizer depth on spi_cs, spi_clk, spi_mosi (minimum 2).
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- spi_clk_polarity  in  1  CPOL; idle level of spi_clk. Static while spi_cs low.
- spi_clk_phase  in  1  CPHA; 0 = sample on leading edge, 1 = sample on trailing edge. Static while spi_cs low.
- data_len  in  8  frame length in bits, legal 1..DATA_W; captured at frame start.
- spi_cs  in  1  chip select from pin, active low, asynchronous.
- spi_clk  in  1  SPI clock from pin, asynchronous.
- spi_mosi  in  1  serial data from master, asynchronous.
- spi_miso  out  1  serial data to master.
- spi_miso_oe  out  1  MISO output enable; high only while frame active.
- tx_data  in  DATA_W  word to transmit, right-justified; captured at frame start.
- tx_taken  out  1  one-cycle pulse when tx_data is captured.
- rx_data  out  DATA_W  last received word, right-justified, upper bits zero.
- rx_valid  out  1  one-cycle pulse: rx_data updated with a complete frame.
- frame_error  out  1  one-cycle pulse: frame ended with bit count != captured data_len.

## Operation
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detection; all sync flops reset to cs=1, clk=0, mosi=0.
- Leading edge = synced spi_clk leaving CPOL level; trailing edge = returning to it.
- FSM states: IDLE, ARMED, ACTIVE.
  - After reset: IDLE. IDLE -> ARMED when synced cs is high (never join a frame already in progress).
  - ARMED -> ACTIVE on synced cs falling edge: capture data_len into len_q, tx_data into tx_sr, pulse tx_taken, clear bit_cnt, rx_sr, overrun.
  - ACTIVE -> ARMED on synced cs rising edge: if bit_cnt == len_q and overrun == 0, rx_data <= rx_sr, pulse rx_valid; else pulse frame_error, rx_data unchanged.
- Sample edge (leading if CPHA=0, trailing if CPHA=1): rx_sr <= {rx_sr, mosi_sync}; bit_cnt++ (saturating at len_q; a sample with bit_cnt==len_q sets overrun).
- Shift edge (trailing if CPHA=0, leading if CPHA=1): tx_sr <= tx_sr << 1. For CPHA=1 the first leading edge shifts nothing (bit len_q-1 already presented); implement via shift only when bit_cnt > 0 or CPHA=0.
- spi_miso = tx_sr[len_q-1] in ACTIVE; 0 otherwise. spi_miso_oe = (state == ACTIVE).
- data_len = 0 or > DATA_W: treated as DATA_W.
- Edges of spi_clk while in IDLE/ARMED ignored.
- Same-cycle cs rise and clk edge: cs rise wins, edge discarded.

## Timing
- Reset values: spi_miso 0, spi_miso_oe 0, tx_taken 0, rx_data 0, rx_valid 0, frame_error 0; state IDLE.
- Pin-to-detection latency: SYNC_STAGES+1 clk cycles for cs and clk edges.
- spi_miso valid SYNC_STAGES+2 clk after the master's shift edge (or cs fall); requires each spi_clk half-period >= SYNC_STAGES+4 clk and cs-fall-to-first-edge >= same.
- rx_valid/frame_error asserted SYNC_STAGES+2 clk after cs pin rises; rx_data stable from that cycle until next rx_valid.
- reset_n asserted mid-frame: immediate return to reset values; new frame only after cs seen high.

## Structure
- Shared package: SPI mode encoding constants (MODE0..MODE3 as {CPOL,CPHA}), FSM state encoding, DATA_W default.
- One sub-module: spi_input_sync (SYNC_STAGES-deep synchronizer with rise/fall pulse outputs), instanced for cs and clk; mosi uses plain sync path.

## Test plan
- Mode 0, data_len=8, tx_data=0x3C, master sends 0xA5 -> MISO bits 0,0,1,1,1,1,0,0; rx_data=0x000000A5, one rx_valid, tx_taken once.
- Mode 3, data_len=16, tx_data=0xBEEF, master sends 0x1234 -> MISO 0xBEEF MSB first, rx_data=0x1234.
- Mode 1, data_len=8, master clocks only 5 bits -> frame_error pulse, no rx_valid, rx_data keeps previous value.
- Mode 2, data_len=8, master clocks 9 bits -> frame_error pulse (overrun), no rx_valid.
- data_len=1 and data_len=32 with master 0xDEADBEEF -> rx_data=0x1 resp. 0xDEADBEEF, MISO matches tx bit 0 resp. 31..0.
- reset_n pulsed after bit 3 of a frame, cs held low -> miso_oe 0, no pulses until cs high then low; next full frame received correctly.
